// File: rtl/psum_seq_pkg.sv
// Shared types and geometry helpers for the psum-memory sequencer.
package psum_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StAcc,
        StFlush
    } state_e;

    function automatic int unsigned nij_len(input int unsigned in_w);
        return in_w * in_w;
    endfunction

    function automatic int unsigned kij_len(input int unsigned k_w);
        return k_w * k_w;
    endfunction

    function automatic int unsigned onij_len(input int unsigned in_w, input int unsigned k_w);
        return (in_w - k_w + 1) * (in_w - k_w + 1);
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Convolution-ordered address generator: kcol innermost, then krow, ocol, orow.
// Counters wrap back to zero after the final address, ready for the next pass.
module conv_addr_gen
    import psum_seq_pkg::*;
#(
    parameter int unsigned IN_W   = 6,
    parameter int unsigned K_W    = 3,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic              last_kij,
    output logic              last_all
);

    localparam int unsigned O_W     = IN_W - K_W + 1;
    localparam int unsigned NIJ_LEN = nij_len(IN_W);

    localparam logic [ADDR_W-1:0] KMax = ADDR_W'(K_W - 1);
    localparam logic [ADDR_W-1:0] OMax = ADDR_W'(O_W - 1);
    localparam logic [ADDR_W-1:0] KwA  = ADDR_W'(K_W);
    localparam logic [ADDR_W-1:0] InwA = ADDR_W'(IN_W);
    localparam logic [ADDR_W-1:0] NijA = ADDR_W'(NIJ_LEN);
    localparam logic [ADDR_W-1:0] One  = ADDR_W'(1);

    logic [ADDR_W-1:0] kcol_q, krow_q, ocol_q, orow_q;

    assign last_kij = (kcol_q == KMax) && (krow_q == KMax);
    assign last_all = last_kij && (ocol_q == OMax) && (orow_q == OMax);

    // kij selects the psum plane; the in-plane offset is the shifted input pixel.
    assign addr = (krow_q * KwA + kcol_q) * NijA
                + (orow_q + krow_q) * InwA + ocol_q + kcol_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            kcol_q <= '0;
            krow_q <= '0;
            ocol_q <= '0;
            orow_q <= '0;
        end else if (en) begin
            if (kcol_q != KMax) begin
                kcol_q <= kcol_q + One;
            end else begin
                kcol_q <= '0;
                if (krow_q != KMax) begin
                    krow_q <= krow_q + One;
                end else begin
                    krow_q <= '0;
                    if (ocol_q != OMax) begin
                        ocol_q <= ocol_q + One;
                    end else begin
                        ocol_q <= '0;
                        orow_q <= (orow_q == OMax) ? '0 : orow_q + One;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/psum_seq_ctrl.sv
// Psum SRAM sequencer: WRITE drains the output FIFO, ACC issues the
// convolution-ordered reads feeding the SFP accumulator (WS or OS order).
module psum_seq_ctrl
    import psum_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned IN_W   = 6,
    parameter int unsigned K_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              os,
    input  logic              start_wr,
    input  logic              start_acc,
    input  logic              ofifo_valid,
    input  logic              sfp_ready,
    output logic              ofifo_rd,
    output logic              psum_cen,
    output logic              psum_wen,
    output logic [ADDR_W-1:0] psum_addr,
    output logic              acc_en,
    output logic              acc_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned NIJ_LEN  = nij_len(IN_W);
    localparam int unsigned KIJ_LEN  = kij_len(K_W);
    localparam int unsigned ONIJ_LEN = onij_len(IN_W, K_W);

    if ((longint'(KIJ_LEN) * longint'(NIJ_LEN) > (longint'(1) << ADDR_W)) || (K_W > IN_W))
    begin : g_bad_params
        $error("psum_seq_ctrl: IN_W/K_W/ADDR_W combination does not fit the psum SRAM");
    end

    localparam logic [ADDR_W-1:0] WsLast   = ADDR_W'(KIJ_LEN * NIJ_LEN - 1);
    localparam logic [ADDR_W-1:0] OnijLast = ADDR_W'(ONIJ_LEN - 1);
    localparam logic [ADDR_W-1:0] One      = ADDR_W'(1);

    state_e            state_q;
    logic              os_q;
    logic [ADDR_W-1:0] lin_q;
    logic              acc_en_q, acc_last_q, done_q;

    logic              wr_fire, rd_fire, gen_en, lin_last, rd_final;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_last_kij, gen_last_all;

    assign wr_fire  = (state_q == StWrite) && ofifo_valid;
    assign rd_fire  = (state_q == StAcc) && sfp_ready;
    assign gen_en   = rd_fire && !os_q;
    // lin_q serves both the write pointer and the OS read pointer.
    assign lin_last = (lin_q == (os_q ? OnijLast : WsLast));
    assign rd_final = os_q ? lin_last : gen_last_all;

    conv_addr_gen #(
        .IN_W   (IN_W),
        .K_W    (K_W),
        .ADDR_W (ADDR_W)
    ) u_conv_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (gen_en),
        .addr     (gen_addr),
        .last_kij (gen_last_kij),
        .last_all (gen_last_all)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            os_q       <= 1'b0;
            lin_q      <= '0;
            acc_en_q   <= 1'b0;
            acc_last_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            acc_en_q   <= rd_fire;
            acc_last_q <= rd_fire && (os_q || gen_last_kij);
            case (state_q)
                StIdle: begin
                    if (start_wr) begin
                        state_q <= StWrite;
                        os_q    <= os;
                    end else if (start_acc) begin
                        state_q <= StAcc;
                        os_q    <= os;
                    end
                end
                StWrite: begin
                    if (ofifo_valid) begin
                        if (lin_last) begin
                            lin_q   <= '0;
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end else begin
                            lin_q <= lin_q + One;
                        end
                    end
                end
                StAcc: begin
                    if (sfp_ready) begin
                        if (os_q) begin
                            lin_q <= lin_last ? '0 : lin_q + One;
                        end
                        if (rd_final) begin
                            state_q <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    state_q <= StIdle;
                    done_q  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ofifo_rd  = wr_fire;
    assign psum_cen  = !(wr_fire || rd_fire);
    assign psum_wen  = !wr_fire;
    assign psum_addr = ((state_q == StAcc) && !os_q) ? gen_addr : lin_q;
    assign acc_en    = acc_en_q;
    assign acc_last  = acc_last_q;
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule

// File: tb/tb_psum_seq_ctrl.sv
// Directed bench for psum_seq_ctrl at IN_W=4, K_W=3 (NIJ=16, KIJ=9, ONIJ=4).
module tb_psum_seq_ctrl;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned IN_W   = 4;
    localparam int unsigned K_W    = 3;

    logic clk, reset, os, start_wr, start_acc, ofifo_valid, sfp_ready;
    logic ofifo_rd, psum_cen, psum_wen, acc_en, acc_last, busy, done;
    logic [ADDR_W-1:0] psum_addr;

    int n_tests = 0;
    int n_fail  = 0;

    psum_seq_ctrl #(
        .ADDR_W (ADDR_W),
        .IN_W   (IN_W),
        .K_W    (K_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .os          (os),
        .start_wr    (start_wr),
        .start_acc   (start_acc),
        .ofifo_valid (ofifo_valid),
        .sfp_ready   (sfp_ready),
        .ofifo_rd    (ofifo_rd),
        .psum_cen    (psum_cen),
        .psum_wen    (psum_wen),
        .psum_addr   (psum_addr),
        .acc_en      (acc_en),
        .acc_last    (acc_last),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst, sw, sa, osm, v, r;
        logic rd, cen, wen;
        int   addr;
        logic ae, al, bsy, dn;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read order from the convolution definition: pixel-major, kij-minor.
    function automatic int exp_addr(input bit os_m, input int idx);
        int p, kij, orow, ocol, krow, kcol;
        if (os_m) return idx;
        p    = idx / 9;
        kij  = idx % 9;
        orow = p / 2;
        ocol = p % 2;
        krow = kij / 3;
        kcol = kij % 3;
        return kij * 16 + (orow + krow) * 4 + ocol + kcol;
    endfunction

    task automatic run_wr(input bit os_m, input int n, input bit gaps);
        int writes = 0;
        int cyc = 0;
        start_wr = 1'b1;
        os = os_m;
        ofifo_valid = 1'b0;
        #2;
        chk("wr_start_busy", busy, 0);
        tick();
        start_wr = 1'b0;
        while (writes < n && cyc < 1000) begin
            ofifo_valid = gaps ? ((cyc % 3) != 1) : 1'b1;
            #2;
            chk("wr_busy", busy, 1);
            chk("wr_done", done, 0);
            chk("wr_ofifo_rd", ofifo_rd, ofifo_valid);
            chk("wr_cen", psum_cen, !ofifo_valid);
            if (ofifo_valid) begin
                chk("wr_wen", psum_wen, 0);
                chk("wr_addr", psum_addr, writes);
                writes++;
            end
            tick();
            cyc++;
        end
        if (writes < n) begin
            chk("wr_budget", writes, n);
            return;
        end
        ofifo_valid = 1'b1;
        #2;
        chk("wr_end_done", done, 1);
        chk("wr_end_busy", busy, 0);
        chk("wr_end_rd", ofifo_rd, 0);
        chk("wr_end_cen", psum_cen, 1);
        tick();
        ofifo_valid = 1'b0;
        #2;
        chk("wr_done_pulse", done, 0);
        tick();
    endtask

    task automatic run_acc(input bit os_m, input bit toggle, input int n_reads, input int terms);
        int  issued = 0;
        int  cyc = 0;
        int  ae_cnt = 0;
        int  al_cnt = 0;
        bit  prev_issue = 1'b0;
        bit  prev_last = 1'b0;
        start_acc = 1'b1;
        os = os_m;
        sfp_ready = 1'b1;
        #2;
        chk("acc_start_busy", busy, 0);
        tick();
        start_acc = 1'b0;
        while (issued < n_reads && cyc < 1000) begin
            sfp_ready = toggle ? ((cyc % 3) == 0) : 1'b1;
            #2;
            chk("acc_busy", busy, 1);
            chk("acc_en", acc_en, prev_issue);
            chk("acc_last", acc_last, prev_last);
            if (acc_en) ae_cnt++;
            if (acc_en && acc_last) al_cnt++;
            chk("acc_cen", psum_cen, !sfp_ready);
            if (sfp_ready) begin
                chk("acc_wen", psum_wen, 1);
                chk($sformatf("acc_addr[%0d]", issued), psum_addr, exp_addr(os_m, issued));
            end
            prev_issue = sfp_ready;
            prev_last  = sfp_ready && (((issued + 1) % terms) == 0);
            if (sfp_ready) issued++;
            tick();
            cyc++;
        end
        if (issued < n_reads) begin
            chk("acc_budget", issued, n_reads);
            return;
        end
        sfp_ready = 1'b1;
        #2;
        chk("flush_cen", psum_cen, 1);
        chk("flush_acc_en", acc_en, 1);
        chk("flush_acc_last", acc_last, 1);
        chk("flush_busy", busy, 1);
        chk("flush_done", done, 0);
        ae_cnt++;
        al_cnt++;
        tick();
        #2;
        chk("acc_end_done", done, 1);
        chk("acc_end_busy", busy, 0);
        chk("acc_end_acc_en", acc_en, 0);
        chk("acc_en_count", ae_cnt, n_reads);
        chk("acc_last_count", al_cnt, n_reads / terms);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        os = 1'b0;
        start_wr = 1'b0;
        start_acc = 1'b0;
        ofifo_valid = 1'b0;
        sfp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_cen", psum_cen, 1);
        chk("rst_wen", psum_wen, 1);
        chk("rst_addr", psum_addr, 0);
        chk("rst_acc_en", acc_en, 0);
        chk("rst_acc_last", acc_last, 0);
        chk("rst_done", done, 0);
        chk("rst_ofifo_rd", ofifo_rd, 0);
        tick();

        run_wr(1'b0, 144, 1'b0);
        run_acc(1'b0, 1'b0, 36, 9);
        run_acc(1'b0, 1'b1, 36, 9);
        run_wr(1'b1, 4, 1'b1);
        run_acc(1'b1, 1'b0, 4, 1);

        // rst sw sa os v r | rd cen wen addr ae al busy done
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            reset       = tbl[i].rst;
            start_wr    = tbl[i].sw;
            start_acc   = tbl[i].sa;
            os          = tbl[i].osm;
            ofifo_valid = tbl[i].v;
            sfp_ready   = tbl[i].r;
            #2;
            chk($sformatf("vec%0d.ofifo_rd", i), ofifo_rd, tbl[i].rd);
            chk($sformatf("vec%0d.cen", i), psum_cen, tbl[i].cen);
            chk($sformatf("vec%0d.wen", i), psum_wen, tbl[i].wen);
            chk($sformatf("vec%0d.addr", i), psum_addr, tbl[i].addr);
            chk($sformatf("vec%0d.acc_en", i), acc_en, tbl[i].ae);
            chk($sformatf("vec%0d.acc_last", i), acc_last, tbl[i].al);
            chk($sformatf("vec%0d.busy", i), busy, tbl[i].bsy);
            chk($sformatf("vec%0d.done", i), done, tbl[i].dn);
            tick();
        end
        reset = 1'b0;
        start_wr = 1'b0;
        start_acc = 1'b0;
        ofifo_valid = 1'b0;

        // Reset lands on the 20th WS read; the next ACC must restart at address 0.
        start_acc = 1'b1;
        os = 1'b0;
        sfp_ready = 1'b1;
        tick();
        start_acc = 1'b0;
        repeat (19) tick();
        #2;
        chk("rst20_addr", psum_addr, 21);
        chk("rst20_cen", psum_cen, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        chk("rst20_after_cen", psum_cen, 1);
        chk("rst20_after_acc_en", acc_en, 0);
        chk("rst20_after_busy", busy, 0);
        chk("rst20_after_addr", psum_addr, 0);
        tick();
        run_acc(1'b0, 1'b0, 36, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_seq_ctrl.md
Name: psum_seq_ctrl

Overview:
Parametrised psum-memory sequencer that replaces the free-running psum address counter in the core top level. It controls the psum SRAM (2048-deep, single-port, active-low CEN/WEN) in two phases:
- WRITE phase: drains the output FIFO into the psum SRAM.
- ACC phase: issues the convolution-aware read sequence that feeds the SFP accumulator.
It supports weight-stationary (WS) and output-stationary (OS) modes, and SFP back-pressure.

Parameters:
ADDR_W, 11, psum SRAM address width
IN_W, 6, input feature-map width (square); NIJ_LEN = IN_W*IN_W
K_W, 3, kernel width (square); KIJ_LEN = K_W*K_W
O_W = IN_W-K_W+1 (derived, localparam); ONIJ_LEN = O_W*O_W
Elaboration error if KIJ_LEN*NIJ_LEN > 2**ADDR_W or K_W > IN_W.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
os  in  1  mode, sampled on accepted start: 0=WS, 1=OS
start_wr  in  1  one-cycle request to begin WRITE phase
start_acc  in  1  one-cycle request to begin ACC phase
ofifo_valid  in  1  output FIFO has a word
sfp_ready  in  1  SFP can accept a psum word this cycle
ofifo_rd  out  1  pop output FIFO (comb)
psum_cen  out  1  psum SRAM chip enable, active-low (comb)
psum_wen  out  1  psum SRAM write enable, active-low (comb)
psum_addr  out  ADDR_W  psum SRAM address (comb from registered counters)
acc_en  out  1  SRAM Q valid for SFP accumulation this cycle (registered)
acc_last  out  1  with acc_en: last term of current output pixel (registered)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on phase completion (registered)

Behaviour:
- Reset values:
  - state = IDLE; all counters = 0.
  - acc_en = acc_last = done = 0; ofifo_rd = 0.
  - psum_cen = 1, psum_wen = 1, psum_addr = 0.
- States: IDLE, WRITE, ACC, FLUSH.
- IDLE:
  - start_wr -> WRITE; start_acc -> ACC.
  - Both asserted together: start_wr wins, start_acc is dropped.
  - os is latched into os_q on the accepted start.
- Starts while busy are ignored; they are not queued.
- WRITE:
  - Each cycle with ofifo_valid=1: ofifo_rd=1, psum_cen=0, psum_wen=0, psum_addr=wr_ptr; wr_ptr increments at the clock edge.
  - ofifo_valid=0: no pop, cen=1, wr_ptr holds.
  - Target count: KIJ_LEN*NIJ_LEN (WS) or ONIJ_LEN (OS).
  - The write of word (target-1) -> IDLE, done=1 next cycle, wr_ptr cleared.
- ACC, WS:
  - Nested counters, innermost first: kcol, krow, ocol, orow.
  - Read address = (krow*K_W+kcol)*NIJ_LEN + (orow+krow)*IN_W + (ocol+kcol).
  - Each cycle with sfp_ready=1: psum_cen=0, psum_wen=1, issue read, advance counters.
  - sfp_ready=0: cen=1, counters hold. No read is lost or duplicated.
- ACC, OS: addresses 0..ONIJ_LEN-1 sequentially; every read is a "last".
- Read latency 1: a read issued in cycle t gives acc_en=1 in t+1. acc_last=1 in t+1 if the read at t was the final kij (WS) or any read (OS).
- After the final read issue -> FLUSH (1 cycle, no SRAM access; lets the last acc_en/acc_last land). Then IDLE with done=1 in the same cycle acc_last of the final pixel is high+1.
- Address arithmetic is unsigned, computed at ADDR_W. Overflow is impossible by the elaboration check.
- Reset mid-phase: the next cycle is IDLE with reset values. Partial psum contents are not cleared.
- WRITE holds the port for its whole duration and ACC never writes, so there is no CEN conflict.

Decomposition:
- Package psum_seq_pkg:
  - state enum (IDLE, WRITE, ACC, FLUSH).
  - functions nij_len/kij_len/onij_len (from IN_W, K_W).
- Sub-module conv_addr_gen:
  - Nested kcol/krow/ocol/orow counters with enable.
  - Combinational address output, last_kij and last_all flags.
  - Parametrised by IN_W, K_W, ADDR_W.
  - Reused later for activation-address generation.

Test Plan:
1. IN_W=4,K_W=3, WS, start_wr, ofifo_valid held 1 -> 144 consecutive writes at addr 0..143, cen=wen=0 each cycle, done pulse 1 cycle after addr 143.
2. Same config, start_acc, sfp_ready=1 -> read addrs 0,17,34,52,69,86,104,121,138 then 1,18,...,139 (36 reads total). acc_last high exactly on the 9th, 18th, 27th and 36th acc_en. done after FLUSH.
3. ACC with sfp_ready toggling 1,0,0,1,... -> address sequence identical to test 2, cen=1 on every ready=0 cycle, acc_en count = 36.
4. OS mode, WRITE with ofifo_valid gaps -> exactly 4 writes at addrs 0..3. ACC -> reads 0,1,2,3 with acc_last on all four.
5. start_wr and start_acc together in IDLE -> WRITE entered. start_acc asserted mid-WRITE -> ignored (busy stays, no ACC afterwards without new start).
6. reset asserted at the 20th ACC read -> next cycle psum_cen=1, acc_en=0, busy=0. A new start_acc restarts at addr 0.
